add16_share_sched: RTL

ADD16_SHARE_SCHED -- requirements
Module: add16_share_sched

---
 rtl/add16_share_sched_if.sv | 30 +++
 rtl/add16_share_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/add16_share_sched_if.sv
// Handshake and data bundle for add16_share_sched.
// master: the requester/consumer side, slave: the shared-adder block.
interface add16_share_sched_if;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [15:0] in_a0;
   logic [15:0] in_b0;
   logic [15:0] in_a1;
   logic [15:0] in_b1;
   logic [1:0]  in_cin;
   logic [1:0]  in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        out_id;
   logic        out_last;
   logic [7:0]  out_idx;

   modport master (
      output in_valid, in_a0, in_b0, in_a1, in_b1, in_cin, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_id, out_last, out_idx
   );

   modport slave (
      input  in_valid, in_a0, in_b0, in_a1, in_b1, in_cin, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_id, out_last, out_idx
   );
endinterface

// File: rtl/add16_share_sched.sv
// One 16-bit adder time-shared between two requesters, one multi-word
// (LSW-first) packet at a time. Round-robin grant on simultaneous requests,
// one-cycle result latency with a single output holding register.
module add16_share_sched (
   input  logic              clk,
   input  logic              rst_n,
   add16_share_sched_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_nxt;
   logic        owner, owner_nxt;
   logic        rr_last;
   logic        carry;
   logic        first;      // next accepted word is word 0 of the packet
   logic [7:0]  idx;        // index of the next word to be accepted
   logic [1:0]  ready;
   logic        accept;
   logic        word_last;
   logic        grant;

   logic [15:0] op_a, op_b;
   logic        c_in;
   logic [16:0] full;
   logic        ovf;

   logic [15:0] sum_q;
   logic        valid_q, cout_q, ovf_q, id_q, last_q;
   logic [7:0]  idx_q;

   // Operand select and the shared adder. A separate first flag (not idx==0)
   // picks cin so the carry chain survives the 255->0 index wrap.
   always_comb begin
      op_a = owner ? bus.in_a1 : bus.in_a0;
      op_b = owner ? bus.in_b1 : bus.in_b0;
      c_in = first ? bus.in_cin[owner] : carry;
      full = {1'b0, op_a} + {1'b0, op_b} + {16'd0, c_in};
      ovf  = (op_a[15] == op_b[15]) && (full[15] != op_a[15]);
      word_last = bus.in_last[owner];
   end

   // Next-state, grant and per-requester ready.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ready     = 2'b00;
      accept    = 1'b0;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.in_valid) begin
               grant     = 1'b1;
               state_nxt = BUSY;
               case (bus.in_valid)
                  2'b01:   owner_nxt = 1'b0;
                  2'b10:   owner_nxt = 1'b1;
                  default: owner_nxt = ~rr_last;
               endcase
            end
         end
         BUSY: begin
            ready[owner] = !valid_q || bus.out_ready;
            accept       = bus.in_valid[owner] && ready[owner];
            if (accept && word_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and owner registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   // Packet bookkeeping and output holding register; a new accept overwrites
   // the held word in the same edge it is drained, so no bubble appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first   <= 1'b0;
         idx     <= 8'd0;
         carry   <= 1'b0;
         rr_last <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= 16'd0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= 8'd0;
      end else begin
         if (grant)
            first <= 1'b1;
         if (accept) begin
            valid_q <= 1'b1;
            sum_q   <= full[15:0];
            cout_q  <= full[16];
            ovf_q   <= ovf;
            id_q    <= owner;
            last_q  <= word_last;
            idx_q   <= idx;
            first   <= 1'b0;
            if (word_last) begin
               idx     <= 8'd0;
               carry   <= 1'b0;
               rr_last <= owner;
            end else begin
               idx     <= idx + 8'd1;
               carry   <= full[16];
            end
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_id    = id_q;
   assign bus.out_last  = last_q;
   assign bus.out_idx   = idx_q;

endmodule
